keypad_scan_debounce: RTL and testbench

Scans a 4x4 matrix keypad, debounces the result and presents a registered 6-bit key word. The word feeds the 6-bit input port of the Nios PIO, which edge-captures it and raises the keypad interrupt. The block sits between the FPGA keypad pins and that PIO, and owns row drive, column sampling, key encoding and debounce.

---
 rtl/keypad_scan_pkg.sv | 25 ++
 rtl/keypad_sync.sv | 23 ++
 rtl/keypad_scan_debounce.sv | 160 ++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared constants, key-word field layout and scan state type for the keypad scanner.
package keypad_scan_pkg;

    localparam int unsigned ROWS            = 4;
    localparam int unsigned COLS            = 4;
    localparam int unsigned KEY_W           = 6;
    localparam int unsigned KEY_CODE_W      = 4;

    localparam int unsigned KEY_CODE_LSB    = 0;
    localparam int unsigned KEY_PRESSED_BIT = 4;
    localparam int unsigned KEY_MULTI_BIT   = 5;

    typedef enum logic {
        IDLE_SCAN,
        PRESS_SCAN
    } scan_state_e;

    // Field order matches key_word so a result can be compared as one value.
    typedef struct packed {
        logic                  multi;
        logic                  pressed;
        logic [KEY_CODE_W-1:0] code;
    } key_res_t;

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the keypad columns; resets to all-ones (idle, pulled up).
module keypad_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with sweep-level debounce producing the PIO key word.
// Optional held-key autorepeat is enabled by defining KEYPAD_SCAN_AUTOREPEAT_EN.
module keypad_scan_debounce
    import keypad_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_SWEEPS = 8,
    parameter int unsigned REPEAT_SWEEPS   = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [COLS-1:0]  col_n,
    output logic [ROWS-1:0]  row_n,
    output logic [KEY_W-1:0] key_word
);

    localparam int unsigned DW_W  = $clog2(SCAN_DIV);
    localparam int unsigned N_W   = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned IMG_W = ROWS * COLS;

    if (SCAN_DIV < 4 || DEBOUNCE_SWEEPS < 1 || REPEAT_SWEEPS < 2) begin : g_bad_params
        $error("keypad_scan_debounce: illegal parameter value");
    end

    logic [COLS-1:0]       col_s;
    logic [ROW_W-1:0]      row;
    logic [DW_W-1:0]       dwell;
    logic [IMG_W-1:0]      image, image_next;
    key_res_t              raw, cand, cand_next;
    logic [N_W-1:0]        run, run_next;
    scan_state_e           state, state_next;
    logic                  multi, multi_next;
    logic [KEY_CODE_W-1:0] code, code_next;
    logic                  sample, sweep_end, accept, gap_next;
    logic [KEY_W-1:0]      key_word_next;

`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_SWEEPS);
    logic [RPT_W-1:0] rpt, rpt_next;
    logic             gap;
`endif

    keypad_sync #(.WIDTH(COLS)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (col_n),
        .q       (col_s)
    );

    assign row_n = ~(ROWS'(1) << row);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE_SCAN;
        else          state <= state_next;
    end

    always_comb begin
        sample     = (dwell == DW_W'(SCAN_DIV - 1));
        sweep_end  = sample && (row == ROW_W'(ROWS - 1));
        image_next = image;
        if (sample) image_next[{row, 2'b00} +: COLS] = ~col_s;

        // Raw result includes the row being sampled on this very cycle.
        raw         = '0;
        raw.pressed = |image_next;
        raw.multi   = |(image_next & (image_next - IMG_W'(1)));
        for (int unsigned i = IMG_W; i > 0; i--) begin
            if (image_next[i-1]) raw.code = KEY_CODE_W'(i - 1);
        end

        cand_next  = cand;
        run_next   = run;
        state_next = state;
        multi_next = multi;
        code_next  = code;
        accept     = 1'b0;
        if (sweep_end) begin
            if (raw != cand) begin
                cand_next = raw;
                run_next  = N_W'(1);
            end else if (run != N_W'(DEBOUNCE_SWEEPS)) begin
                run_next = run + N_W'(1);
            end
            // A released candidate only differs from stable in the pressed flag;
            // the retained code must not count as a difference.
            if (run_next == N_W'(DEBOUNCE_SWEEPS)) begin
                if (cand_next.pressed)
                    accept = (state == IDLE_SCAN) || (cand_next.code != code)
                             || (cand_next.multi != multi);
                else
                    accept = (state == PRESS_SCAN);
            end
            if (accept) begin
                state_next = cand_next.pressed ? PRESS_SCAN : IDLE_SCAN;
                multi_next = cand_next.multi;
                if (cand_next.pressed) code_next = cand_next.code;
            end
        end

`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
        rpt_next = rpt;
        gap_next = gap;
        if (sweep_end) begin
            if (state_next != PRESS_SCAN || state == IDLE_SCAN || code_next != code) begin
                rpt_next = '0;
                gap_next = 1'b0;
            end else if (rpt == RPT_W'(REPEAT_SWEEPS - 1)) begin
                rpt_next = '0;
                gap_next = 1'b1;
            end else begin
                rpt_next = rpt + RPT_W'(1);
                gap_next = 1'b0;
            end
        end
`else
        gap_next = 1'b0;
`endif

        key_word_next                                   = '0;
        key_word_next[KEY_CODE_LSB +: KEY_CODE_W]       = code_next;
        key_word_next[KEY_PRESSED_BIT]                  = (state_next == PRESS_SCAN) && !gap_next;
        key_word_next[KEY_MULTI_BIT]                    = multi_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row      <= '0;
            dwell    <= '0;
            image    <= '0;
            cand     <= '0;
            run      <= '0;
            multi    <= 1'b0;
            code     <= '0;
            key_word <= '0;
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
            rpt      <= '0;
            gap      <= 1'b0;
`endif
        end else begin
            if (sample) begin
                dwell <= '0;
                row   <= row + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
            image    <= image_next;
            cand     <= cand_next;
            run      <= run_next;
            multi    <= multi_next;
            code     <= code_next;
            key_word <= key_word_next;
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
            rpt      <= rpt_next;
            gap      <= gap_next;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench for keypad_scan_debounce against a sweep-level reference model.
// Expectations follow KEYPAD_SCAN_AUTOREPEAT_EN when it is defined for the build.
module tb_keypad_scan_debounce;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned RPT      = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [5:0] key_word;
    logic [15:0] keys = '0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned cyc;
    logic [15:0] m_img;
    logic [5:0]  hist[$];
    logic        m_pressed, m_multi, m_gap;
    logic [3:0]  m_code;
    int unsigned held;
    logic [5:0]  exp_kw;
    logic [3:0]  exp_row;

    keypad_scan_debounce #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_SWEEPS (DEB),
        .REPEAT_SWEEPS   (RPT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_word (key_word)
    );

    always #5 clk = ~clk;

    // Physical keypad: a closed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
    end

    function automatic void model_reset();
        cyc       = 0;
        m_img     = '0;
        hist.delete();
        m_pressed = 1'b0;
        m_multi   = 1'b0;
        m_code    = '0;
        m_gap     = 1'b0;
        held      = 0;
        exp_kw    = '0;
        exp_row   = 4'b1110;
    endfunction

    function automatic void model_sweep();
        logic [5:0] raw;
        logic [5:0] v;
        bit         same;
        bit         new_code;
        raw    = '0;
        raw[4] = (m_img != 16'h0);
        raw[5] = ($countones(m_img) > 1);
        for (int i = 15; i >= 0; i--)
            if (m_img[i]) raw[3:0] = 4'(i);
        hist.push_back(raw);
        if (hist.size() > DEB) void'(hist.pop_front());
        new_code = 1'b0;
        if (hist.size() == DEB) begin
            same = 1'b1;
            foreach (hist[k]) if (hist[k] !== hist[0]) same = 1'b0;
            v = hist[0];
            if (same) begin
                if (v[4] && (!m_pressed || v[3:0] != m_code || v[5] != m_multi)) begin
                    new_code  = !m_pressed || (v[3:0] != m_code);
                    m_pressed = 1'b1;
                    m_multi   = v[5];
                    m_code    = v[3:0];
                end else if (!v[4] && m_pressed) begin
                    m_pressed = 1'b0;
                    m_multi   = 1'b0;
                end
            end
        end
        if (!m_pressed || new_code) held = 0;
        else                        held++;
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
        m_gap = m_pressed && (held != 0) && (held % RPT == 0);
`else
        m_gap = 1'b0;
`endif
        exp_kw = {m_multi, m_pressed & ~m_gap, m_code};
    endfunction

    // One clock, then let the model see the rows sampled on that edge.
    task automatic tick();
        int unsigned r;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc % SCAN_DIV == 0) begin
            r = (cyc / SCAN_DIV - 1) % 4;
            m_img[r*4 +: 4] = keys[r*4 +: 4];
            if (r == 3) model_sweep();
        end
        exp_row = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
    endtask

    task automatic assert_reset();
        #2 reset_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic align_sweep();
        while (cyc % (4 * SCAN_DIV) != 0) tick();
    endtask

    task automatic test_reset();
        keys = '0;
        release_reset();
        repeat (23) begin
            tick();
            checks++;
            if (key_word !== exp_kw || row_n !== exp_row) begin
                errors++;
                $display("FAIL reset_run cyc=%0d key_word=%h row_n=%b expected %h %b", cyc, key_word, row_n, exp_kw, exp_row);
            end
        end
        assert_reset();
        checks++;
        if (row_n !== 4'b1110) begin
            errors++;
            $display("FAIL reset_row row_n=%b expected 1110", row_n);
        end
        checks++;
        if (key_word !== 6'h00) begin
            errors++;
            $display("FAIL reset_key key_word=%h expected 00", key_word);
        end
        release_reset();
        repeat (32) begin
            tick();
            checks++;
            if (key_word !== exp_kw || row_n !== exp_row) begin
                errors++;
                $display("FAIL reset_rows cyc=%0d key_word=%h row_n=%b expected %h %b", cyc, key_word, row_n, exp_kw, exp_row);
            end
        end
    endtask

    task automatic test_single_press();
        align_sweep();
        keys = 16'h1 << 9;
        for (int t = 1; t <= 48; t++) begin
            tick();
            checks++;
            if (key_word !== exp_kw || row_n !== exp_row) begin
                errors++;
                $display("FAIL press_model cyc=%0d key_word=%h row_n=%b expected %h %b", cyc, key_word, row_n, exp_kw, exp_row);
            end
            if (t == 47 || t == 48) begin
                checks++;
                if (key_word !== ((t == 48) ? 6'h19 : 6'h00)) begin
                    errors++;
                    $display("FAIL press_latency t=%0d key_word=%h expected %h", t, key_word, (t == 48) ? 6'h19 : 6'h00);
                end
            end
        end
        keys = '0;
        for (int t = 1; t <= 48; t++) begin
            tick();
            checks++;
            if (key_word !== exp_kw || row_n !== exp_row) begin
                errors++;
                $display("FAIL release_model cyc=%0d key_word=%h row_n=%b expected %h %b", cyc, key_word, row_n, exp_kw, exp_row);
            end
            if (t == 47 || t == 48) begin
                checks++;
                if (key_word !== ((t == 48) ? 6'h09 : 6'h19)) begin
                    errors++;
                    $display("FAIL release_latency t=%0d key_word=%h expected %h", t, key_word, (t == 48) ? 6'h09 : 6'h19);
                end
            end
        end
    endtask

    task automatic test_bounce();
        assert_reset();
        release_reset();
        for (int s = 0; s < 9; s++) begin
            keys = (s < 6 && s % 2 == 1) ? 16'h0 : (16'h1 << 9);
            for (int t = 1; t <= 16; t++) begin
                tick();
                checks++;
                if (key_word !== exp_kw || row_n !== exp_row) begin
                    errors++;
                    $display("FAIL bounce_model cyc=%0d key_word=%h row_n=%b expected %h %b", cyc, key_word, row_n, exp_kw, exp_row);
                end
            end
            checks++;
            if (key_word !== ((s == 8) ? 6'h19 : 6'h00)) begin
                errors++;
                $display("FAIL bounce_sweep s=%0d key_word=%h expected %h", s, key_word, (s == 8) ? 6'h19 : 6'h00);
            end
        end
    endtask

    task automatic test_multi_key();
        align_sweep();
        keys = (16'h1 << 3) | (16'h1 << 12);
        repeat (48) begin
            tick();
            checks++;
            if (key_word !== exp_kw || row_n !== exp_row) begin
                errors++;
                $display("FAIL multi_model cyc=%0d key_word=%h row_n=%b expected %h %b", cyc, key_word, row_n, exp_kw, exp_row);
            end
        end
        checks++;
        if (key_word !== 6'h33) begin
            errors++;
            $display("FAIL multi_word key_word=%h expected 33", key_word);
        end
    endtask

    task automatic test_mid_reset();
        align_sweep();
        keys = 16'h1 << 6;
        repeat (69) begin
            tick();
            checks++;
            if (key_word !== exp_kw || row_n !== exp_row) begin
                errors++;
                $display("FAIL midrst_model cyc=%0d key_word=%h row_n=%b expected %h %b", cyc, key_word, row_n, exp_kw, exp_row);
            end
        end
        assert_reset();
        checks++;
        if (key_word !== 6'h00 || row_n !== 4'b1110) begin
            errors++;
            $display("FAIL midrst_assert key_word=%h row_n=%b expected 00 1110", key_word, row_n);
        end
        release_reset();
        for (int t = 1; t <= 48; t++) begin
            tick();
            checks++;
            if (key_word !== exp_kw || row_n !== exp_row) begin
                errors++;
                $display("FAIL midrst_resume cyc=%0d key_word=%h row_n=%b expected %h %b", cyc, key_word, row_n, exp_kw, exp_row);
            end
        end
        checks++;
        if (key_word !== 6'h16) begin
            errors++;
            $display("FAIL midrst_word key_word=%h expected 16", key_word);
        end
    endtask

    task automatic test_autorepeat();
        int low = 0;
        int bad_code = 0;
        int exp_low;
`ifdef KEYPAD_SCAN_AUTOREPEAT_EN
        exp_low = 32;
`else
        exp_low = 0;
`endif
        assert_reset();
        keys = 16'h1 << 5;
        release_reset();
        for (int t = 1; t <= 224; t++) begin
            tick();
            checks++;
            if (key_word !== exp_kw || row_n !== exp_row) begin
                errors++;
                $display("FAIL repeat_model cyc=%0d key_word=%h row_n=%b expected %h %b", cyc, key_word, row_n, exp_kw, exp_row);
            end
            if (t >= 48) begin
                if (key_word[4] !== 1'b1) low++;
                if (key_word[3:0] !== 4'd5 || key_word[5] !== 1'b0) bad_code++;
            end
        end
        checks++;
        if (low !== exp_low) begin
            errors++;
            $display("FAIL repeat_low_cycles got=%0d expected %0d", low, exp_low);
        end
        checks++;
        if (bad_code !== 0) begin
            errors++;
            $display("FAIL repeat_code bad_cycles=%0d expected 0", bad_code);
        end
    endtask

    task automatic test_random();
        int unsigned pick;
        int unsigned hold;
        while (cyc % SCAN_DIV != 0) tick();
        for (int it = 0; it < 60; it++) begin
            pick = $urandom_range(0, 9);
            if (pick < 4)      keys = '0;
            else if (pick < 9) keys = 16'h1 << $urandom_range(0, 15);
            else               keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            hold = $urandom_range(1, 24);
            repeat (hold * SCAN_DIV) begin
                tick();
                checks++;
                if (key_word !== exp_kw || row_n !== exp_row) begin
                    errors++;
                    $display("FAIL random it=%0d cyc=%0d keys=%h key_word=%h row_n=%b expected %h %b", it, cyc, keys, key_word, row_n, exp_kw, exp_row);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_mid_reset();
        test_autorepeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
